// File: rtl/rot_quad_if.sv
// Command handshake bundle for the rotary-encoder emulator.
// Master offers detent/press commands; slave accepts when idle.
interface rot_quad_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_press;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_count,
    output cmd_press,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_count,
    input  cmd_press,
    output cmd_ready
  );
endinterface

// File: rtl/rot_quad_gen.sv
// Rotary-encoder emulator: step/press commands to detent-accurate
// quadrature A/B plus push-switch level, all outputs registered.
module rot_quad_gen #(
  parameter int PHASE_CYCLES = 16,
  parameter int CNT_W        = 8,
  parameter int PRESS_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  rot_quad_if.slave  cmd,
  output logic       rot_a,
  output logic       rot_b,
  output logic       rot_press,
  output logic       busy,
  output logic       done
);

  localparam int MAXC =
    (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
  localparam int PW = $clog2(MAXC) + 1;

  localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [PW-1:0] PR_LAST = PW'(PRESS_CYCLES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PH1   = 3'd1;
  localparam logic [2:0] PH2   = 3'd2;
  localparam logic [2:0] PH3   = 3'd3;
  localparam logic [2:0] PH4   = 3'd4;
  localparam logic [2:0] PRESS = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]       st, st_n;
  logic [PW-1:0]    cnt, cnt_n;
  logic [CNT_W-1:0] steps, steps_n;
  logic             dir_q, dir_n;
  logic             prs_q, prs_n;
  logic [1:0]       ab, ab_n;
  logic             press_n;
  logic             accept;
  logic             ph_end;
  logic             pr_end;

  assign cmd.cmd_ready = (st == IDLE);
  assign busy          = (st != IDLE);
  assign done          = (st == DONE);

  assign accept = cmd.cmd_valid && (st == IDLE);
  assign ph_end = (cnt == PH_LAST);
  assign pr_end = (cnt == PR_LAST);

  always_comb begin
    st_n    = st;
    cnt_n   = cnt + 1'b1;
    steps_n = steps;
    dir_n   = dir_q;
    prs_n   = prs_q;
    unique case (st)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          dir_n   = cmd.cmd_dir;
          prs_n   = cmd.cmd_press;
          steps_n = cmd.cmd_count;
          if (cmd.cmd_count != '0)
            st_n = PH1;
          else if (cmd.cmd_press)
            st_n = PRESS;
          else
            st_n = DONE;
        end
      end
      PH1: if (ph_end) begin
        cnt_n = '0;
        st_n  = PH2;
      end
      PH2: if (ph_end) begin
        cnt_n = '0;
        st_n  = PH3;
      end
      PH3: if (ph_end) begin
        cnt_n = '0;
        st_n  = PH4;
      end
      PH4: if (ph_end) begin
        cnt_n   = '0;
        steps_n = steps - 1'b1;
        // steps still holds the pre-decrement value here
        if (steps != CNT_W'(1))
          st_n = PH1;
        else if (prs_q)
          st_n = PRESS;
        else
          st_n = DONE;
      end
      PRESS: if (pr_end) begin
        cnt_n = '0;
        st_n  = DONE;
      end
      DONE: begin
        cnt_n = '0;
        st_n  = IDLE;
      end
      default: begin
        cnt_n = '0;
        st_n  = IDLE;
      end
    endcase
  end

  // {b,a} for a right turn; a left turn swaps the two lines
  always_comb begin
    ab = 2'b00;
    unique case (1'b1)
      (st_n == PH1): ab = 2'b01;
      (st_n == PH2): ab = 2'b11;
      (st_n == PH3): ab = 2'b10;
      default:       ab = 2'b00;
    endcase
    ab_n    = dir_n ? {ab[0], ab[1]} : ab;
    press_n = (st_n == PRESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      steps     <= '0;
      dir_q     <= 1'b0;
      prs_q     <= 1'b0;
      rot_a     <= 1'b0;
      rot_b     <= 1'b0;
      rot_press <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      steps     <= steps_n;
      dir_q     <= dir_n;
      prs_q     <= prs_n;
      rot_b     <= ab_n[1];
      rot_a     <= ab_n[0];
      rot_press <= press_n;
    end
  end

endmodule

// File: tb/tb_rot_quad_gen.sv
// Scoreboard bench for rot_quad_gen: per-cycle waveform queue plus
// a quadrature decoder model checked at each done pulse.
module tb_rot_quad_gen;
  localparam int P  = 4;
  localparam int PR = 5;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rot_a, rot_b, rot_press, busy, done;

  rot_quad_if #(.CNT_W(W)) bus ();

  rot_quad_gen #(
    .PHASE_CYCLES(P),
    .CNT_W(W),
    .PRESS_CYCLES(PR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(bus),
    .rot_a(rot_a),
    .rot_b(rot_b),
    .rot_press(rot_press),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // sample = {b, a, press, done}
  logic [3:0]  exp_q[$];
  logic [15:0] res_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  task automatic push_model(input logic d, input logic [W-1:0] n,
                            input logic p);
    logic [1:0] pat[4];
    int delta;
    if (d) begin
      pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b00;
    end else begin
      pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b10; pat[3] = 2'b00;
    end
    for (int i = 0; i < int'(n); i++)
      for (int ph = 0; ph < 4; ph++)
        for (int c = 0; c < P; c++)
          exp_q.push_back({pat[ph], 2'b00});
    if (p)
      for (int c = 0; c < PR; c++)
        exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    delta = 8 * int'(n);
    res_q.push_back(d ? 16'(32'h2000 - delta) : 16'(32'h2000 + delta));
  endtask

  // Monitor: decoder model, Gray check and waveform scoreboard
  logic [1:0]  prev_ba = 2'b00;
  logic        busy_prev = 1'b0;
  logic [15:0] dec = 16'h2000;
  int          glitch = 0;

  always @(negedge clk) begin
    logic [1:0] ba;
    logic [3:0] s;
    logic [15:0] r;
    if (!rst_n) begin
      prev_ba   = 2'b00;
      busy_prev = 1'b0;
    end else begin
      ba = {rot_b, rot_a};
      if (busy && !busy_prev) begin
        dec    = 16'h2000;
        glitch = 0;
      end
      if (ba != prev_ba) begin
        if (ba[0] != prev_ba[0] && ba[1] != prev_ba[1]) glitch++;
        if (ba == 2'b11 && prev_ba == 2'b01) dec = dec + 16'd8;
        if (ba == 2'b11 && prev_ba == 2'b10) dec = dec - 16'd8;
      end
      prev_ba = ba;
      if (busy) begin
        check("ready_busy", 32'(bus.cmd_ready), 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_busy");
        end else begin
          s = exp_q.pop_front();
          check("wave", 32'({rot_b, rot_a, rot_press, done}), 32'(s));
        end
        if (done) begin
          if (res_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            r = res_q.pop_front();
            check("decoder", 32'(dec), 32'(r));
            check("gray", 32'(glitch), 32'd0);
          end
        end
      end else begin
        check("idle", 32'({rot_b, rot_a, rot_press, done, bus.cmd_ready}),
              32'b00001);
      end
      busy_prev = busy;
    end
  end

  task automatic send(input logic d, input logic [W-1:0] n, input logic p);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = d;
    bus.cmd_count = n;
    bus.cmd_press = p;
    for (int i = 0; i < 20000; i++) begin
      if (bus.cmd_ready) begin
        push_model(d, n, p);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'($urandom);
        bus.cmd_count = W'($urandom);
        bus.cmd_press = 1'($urandom);
        return;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    fail_now("accept_timeout");
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) return;
    end
    fail_now("idle_timeout");
  endtask

  initial begin
    int acc;
    logic d;
    logic [W-1:0] n;
    logic p;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_press = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_out", 32'({rot_b, rot_a, rot_press, busy, done}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    send(1'b0, W'(3), 1'b0);
    wait_idle(200);
    send(1'b1, W'(2), 1'b0);
    wait_idle(200);
    send(1'b0, W'(0), 1'b1);
    wait_idle(50);
    send(1'b1, W'(0), 1'b0);
    wait_idle(50);

    // cmd_valid held high with fields changing every cycle
    acc = 0;
    @(negedge clk);
    for (int k = 0; k < 400 && acc < 2; k++) begin
      if (k == 0) begin
        d = 1'b0; n = W'(2); p = 1'b0;
      end else begin
        d = 1'($urandom);
        n = W'($urandom_range(0, 3));
        p = 1'($urandom);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = d;
      bus.cmd_count = n;
      bus.cmd_press = p;
      if (bus.cmd_ready) begin
        push_model(d, n, p);
        acc++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("hold_accepts", 32'(acc), 32'd2);
    wait_idle(200);

    // reset during PH2 of step 2 of a 4-step command
    send(1'b0, W'(4), 1'b0);
    repeat (21) @(negedge clk);
    check("pre_reset_ph2", 32'({rot_b, rot_a}), 32'b11);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    res_q.delete();
    #1;
    check("async_reset", 32'({rot_b, rot_a, rot_press, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    check("no_done_in_reset", 32'(done), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rel", 32'(bus.cmd_ready), 32'd1);
    send(1'b1, W'(1), 1'b1);
    wait_idle(200);

    repeat (15)
      send(1'($urandom), W'($urandom_range(0, 5)), 1'($urandom));
    wait_idle(400);

    send(1'b0, W'(255), 1'b0);
    wait_idle(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
